// File: rtl/gpcfg_rdata_tree_if.sv
// Read-data bus between the config register bank and the reduction tree.
// The bank side drives sources, hits and qualifiers. The tree side returns
// the reduced AHB read data and the decode-error status.
interface gpcfg_rdata_tree_if #(
    parameter int NUM_RDATA = 1024,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
);
    logic [NUM_RDATA*DATA_W-1:0] rdata;
    logic [NUM_RDATA-1:0]        rd_hit;
    logic                        valid_rd;
    logic                        err_clr;
    logic [DATA_W-1:0]           hrdata;
    logic                        hrdata_vld;
    logic                        rd_err;
    logic                        nohit_sticky;
    logic                        multihit_sticky;
    logic [ERR_CNT_W-1:0]        err_cnt;

    modport master (
        output rdata, rd_hit, valid_rd, err_clr,
        input  hrdata, hrdata_vld, rd_err, nohit_sticky, multihit_sticky, err_cnt
    );

    modport slave (
        input  rdata, rd_hit, valid_rd, err_clr,
        output hrdata, hrdata_vld, rd_err, nohit_sticky, multihit_sticky, err_cnt
    );
endinterface

// File: rtl/gpcfg_rdata_tree.sv
// Two-stage pipelined OR reduction of one-hot config-register read buses.
// Stage 1 registers a masked partial OR and a saturating hit count per group.
// Stage 2 merges the groups, then resolves no-hit and multi-hit decode errors
// into an error response, sticky flags and a saturating error counter.
module gpcfg_rdata_tree #(
    parameter int                NUM_RDATA  = 1024,
    parameter int                DATA_W     = 32,
    parameter int                NUM_GROUPS = 4,
    parameter int                ERR_CNT_W  = 8,
    parameter logic [DATA_W-1:0] ERR_DATA   = '0
) (
    input logic               hclk,
    input logic               hresetn,
    gpcfg_rdata_tree_if.slave bus
);

    // Sources per group; trailing groups may be short or empty.
    localparam int GSZ = (NUM_RDATA + NUM_GROUPS - 1) / NUM_GROUPS;

    logic [DATA_W-1:0] grp_data [NUM_GROUPS];
    logic [1:0]        grp_cnt  [NUM_GROUPS];
    logic [DATA_W-1:0] s1_data  [NUM_GROUPS];
    logic [1:0]        s1_hcnt  [NUM_GROUPS];
    logic              s1_vld;

    logic [DATA_W-1:0] or_data;
    logic [1:0]        total;
    logic [2:0]        sum3;
    logic              set_nohit;
    logic              set_multi;
    logic              beat_err;

    // Per-group masked OR and saturating (0/1/2+) hit count.
    always_comb begin
        // NOTE: every comb output gets a default before the loop so no path
        // leaves it unassigned and no latch is inferred.
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_data[g] = '0;
            grp_cnt[g]  = 2'd0;
        end
        for (int i = 0; i < NUM_RDATA; i++) begin
            if (bus.rd_hit[i]) begin
                grp_data[i / GSZ] = grp_data[i / GSZ] | bus.rdata[i*DATA_W +: DATA_W];
                if (grp_cnt[i / GSZ] != 2'd2) begin
                    grp_cnt[i / GSZ] = grp_cnt[i / GSZ] + 2'd1;
                end
            end
        end
    end

    // Stage 1 register; idle cycles load zeros so idle data stays zero.
    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!hresetn) begin
            s1_vld <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                s1_data[g] <= '0;
                s1_hcnt[g] <= 2'd0;
            end
        end else begin
            s1_vld <= bus.valid_rd;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                s1_data[g] <= bus.valid_rd ? grp_data[g] : '0;
                s1_hcnt[g] <= bus.valid_rd ? grp_cnt[g]  : 2'd0;
            end
        end
    end

    // Merge groups: final OR and total hits capped at 2.
    always_comb begin
        or_data = '0;
        total   = 2'd0;
        sum3    = 3'd0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            or_data = or_data | s1_data[g];
            sum3    = {1'b0, total} + {1'b0, s1_hcnt[g]};
            total   = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];
        end
        set_nohit = s1_vld && (total == 2'd0);
        set_multi = s1_vld && (total == 2'd2);
        beat_err  = set_nohit || set_multi;
    end

    // Stage 2 register: response data, error flag, sticky status, counter.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            bus.hrdata          <= '0;
            bus.hrdata_vld      <= 1'b0;
            bus.rd_err          <= 1'b0;
            bus.nohit_sticky    <= 1'b0;
            bus.multihit_sticky <= 1'b0;
            bus.err_cnt         <= '0;
        end else begin
            bus.hrdata_vld <= s1_vld;
            bus.rd_err     <= beat_err;
            if (!s1_vld) begin
                bus.hrdata <= '0;
            end else if (beat_err) begin
                bus.hrdata <= ERR_DATA;
            end else begin
                bus.hrdata <= or_data;
            end

            // A new error outranks a clear so the event is never lost.
            if (set_nohit) begin
                bus.nohit_sticky <= 1'b1;
            end else if (bus.err_clr) begin
                bus.nohit_sticky <= 1'b0;
            end
            if (set_multi) begin
                bus.multihit_sticky <= 1'b1;
            end else if (bus.err_clr) begin
                bus.multihit_sticky <= 1'b0;
            end

            // Clear outranks an increment; the count saturates at all-ones.
            if (bus.err_clr) begin
                bus.err_cnt <= '0;
            end else if (beat_err && !(&bus.err_cnt)) begin
                bus.err_cnt <= bus.err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpcfg_rdata_tree.sv
// Self-checking bench for gpcfg_rdata_tree: directed test-plan sequences with
// literal expectations, then randomized traffic, all compared every cycle
// against a flat (group-free) behavioural model.
module tb_gpcfg_rdata_tree;

    localparam int                NUM_RDATA  = 1024;
    localparam int                DATA_W     = 32;
    localparam int                NUM_GROUPS = 4;
    localparam int                ERR_CNT_W  = 2;
    localparam logic [DATA_W-1:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int                CNT_MAX    = (1 << ERR_CNT_W) - 1;

    logic hclk;
    logic hresetn;

    gpcfg_rdata_tree_if #(
        .NUM_RDATA (NUM_RDATA),
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) bus ();

    gpcfg_rdata_tree #(
        .NUM_RDATA  (NUM_RDATA),
        .DATA_W     (DATA_W),
        .NUM_GROUPS (NUM_GROUPS),
        .ERR_CNT_W  (ERR_CNT_W),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A read is summarised by its qualifier, its total hit count and the OR
    // of the hit sources; the response appears one edge after it is captured.
    typedef struct {
        bit                vld;
        int                hits;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             pend;
    bit                exp_vld   = 1'b0;
    bit                exp_err   = 1'b0;
    logic [DATA_W-1:0] exp_data  = '0;
    bit                exp_nohit = 1'b0;
    bit                exp_multi = 1'b0;
    int                exp_cnt   = 0;
    bit                cmp_en    = 1'b0;

    function automatic beat_t capture();
        beat_t b;
        b.vld  = bus.valid_rd;
        b.hits = 0;
        b.data = '0;
        if (bus.valid_rd) begin
            for (int i = 0; i < NUM_RDATA; i++) begin
                if (bus.rd_hit[i]) begin
                    b.hits++;
                    b.data |= bus.rdata[i*DATA_W +: DATA_W];
                end
            end
        end
        return b;
    endfunction

    initial begin
        pend.vld  = 1'b0;
        pend.hits = 0;
        pend.data = '0;
    end

    always @(posedge hclk) begin
        if (!hresetn) begin
            pend.vld  = 1'b0;
            pend.hits = 0;
            pend.data = '0;
            exp_vld   = 1'b0;
            exp_err   = 1'b0;
            exp_data  = '0;
            exp_nohit = 1'b0;
            exp_multi = 1'b0;
            exp_cnt   = 0;
        end else begin
            exp_vld  = pend.vld;
            exp_err  = pend.vld && (pend.hits != 1);
            exp_data = !pend.vld ? '0 : (exp_err ? ERR_DATA : pend.data);
            if (pend.vld && pend.hits == 0) exp_nohit = 1'b1;
            else if (bus.err_clr)           exp_nohit = 1'b0;
            if (pend.vld && pend.hits >= 2) exp_multi = 1'b1;
            else if (bus.err_clr)           exp_multi = 1'b0;
            if (bus.err_clr)                       exp_cnt = 0;
            else if (exp_err && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
            pend = capture();
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge hclk) begin
        if (cmp_en) begin
            check("m_hrdata_vld", 64'(bus.hrdata_vld), 64'(exp_vld));
            check("m_hrdata", 64'(bus.hrdata), 64'(exp_data));
            check("m_rd_err", 64'(bus.rd_err), 64'(exp_err));
            check("m_nohit_sticky", 64'(bus.nohit_sticky), 64'(exp_nohit));
            check("m_multihit_sticky", 64'(bus.multihit_sticky), 64'(exp_multi));
            check("m_err_cnt", 64'(bus.err_cnt), 64'(exp_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge hclk);
    endtask

    task automatic go_idle();
        bus.valid_rd = 1'b0;
        bus.rd_hit   = '0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic fill_data(input logic [DATA_W-1:0] val);
        for (int i = 0; i < NUM_RDATA; i++) bus.rdata[i*DATA_W +: DATA_W] = val;
    endtask

    task automatic read_hits(input int a, input int b, input int c);
        bus.rd_hit = '0;
        if (a >= 0) bus.rd_hit[a] = 1'b1;
        if (b >= 0) bus.rd_hit[b] = 1'b1;
        if (c >= 0) bus.rd_hit[c] = 1'b1;
        bus.valid_rd = 1'b1;
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    int bnd [7] = '{255, 256, 511, 512, 767, 768, 1023};

    initial begin
        hresetn = 1'b0;
        go_idle();
        fill_data('0);
        tick();
        cmp_en = 1'b1;
        tick();
        check("reset_hrdata", 64'(bus.hrdata), 64'h0);
        check("reset_vld", 64'(bus.hrdata_vld), 64'h0);
        check("reset_err_cnt", 64'(bus.err_cnt), 64'h0);
        hresetn = 1'b1;
        tick();

        // Single hit with all other sources all-ones.
        fill_data(32'hFFFF_FFFF);
        bus.rdata[5*DATA_W +: DATA_W] = 32'h1234_5678;
        read_hits(5, -1, -1);
        tick();
        go_idle();
        tick();
        check("single_hrdata", 64'(bus.hrdata), 64'h1234_5678);
        check("single_vld", 64'(bus.hrdata_vld), 64'h1);
        check("single_err", 64'(bus.rd_err), 64'h0);

        // Group boundaries, back-to-back.
        for (int i = 0; i < NUM_RDATA; i++) bus.rdata[i*DATA_W +: DATA_W] = DATA_W'(i);
        for (int j = 0; j <= 7; j++) begin
            if (j < 7) read_hits(bnd[j], -1, -1);
            else       go_idle();
            tick();
            if (j >= 1) begin
                check("bound_hrdata", 64'(bus.hrdata), 64'(bnd[j-1]));
                check("bound_vld", 64'(bus.hrdata_vld), 64'h1);
            end
        end
        tick();

        // No-hit read.
        read_hits(-1, -1, -1);
        tick();
        go_idle();
        tick();
        check("nohit_hrdata", 64'(bus.hrdata), 64'(ERR_DATA));
        check("nohit_err", 64'(bus.rd_err), 64'h1);
        check("nohit_sticky", 64'(bus.nohit_sticky), 64'h1);
        check("nohit_cnt", 64'(bus.err_cnt), 64'h1);
        clear_errs();

        // Multi-hit across groups.
        read_hits(10, 600, -1);
        tick();
        go_idle();
        tick();
        check("multi_err", 64'(bus.rd_err), 64'h1);
        check("multi_sticky", 64'(bus.multihit_sticky), 64'h1);
        check("multi_cnt", 64'(bus.err_cnt), 64'h1);
        clear_errs();
        check("clr_multi", 64'(bus.multihit_sticky), 64'h0);

        // Three hits inside one group.
        read_hits(1, 2, 3);
        tick();
        go_idle();
        tick();
        check("multi3_sticky", 64'(bus.multihit_sticky), 64'h1);
        clear_errs();

        // Counter saturation, then clear colliding with an errored beat.
        for (int j = 0; j < 5; j++) begin
            read_hits(-1, -1, -1);
            tick();
        end
        go_idle();
        tick();
        tick();
        check("sat_cnt", 64'(bus.err_cnt), 64'(CNT_MAX));
        read_hits(-1, -1, -1);
        tick();
        go_idle();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_wins_cnt", 64'(bus.err_cnt), 64'h0);
        check("set_wins_sticky", 64'(bus.nohit_sticky), 64'h1);
        check("clr_err_beat", 64'(bus.rd_err), 64'h1);

        // Mid-flight reset discards the in-flight read.
        read_hits(7, -1, -1);
        tick();
        go_idle();
        hresetn = 1'b0;
        tick();
        check("rst_vld", 64'(bus.hrdata_vld), 64'h0);
        check("rst_hrdata", 64'(bus.hrdata), 64'h0);
        check("rst_sticky", 64'(bus.nohit_sticky), 64'h0);
        hresetn = 1'b1;
        tick();
        check("post_rst_vld", 64'(bus.hrdata_vld), 64'h0);
        check("post_rst_cnt", 64'(bus.err_cnt), 64'h0);

        // Randomized traffic, including hits while idle, clears and resets.
        for (int c = 0; c < 400; c++) begin
            int kind;
            for (int i = 0; i < NUM_RDATA; i++) bus.rdata[i*DATA_W +: DATA_W] = $urandom();
            bus.rd_hit = '0;
            kind = int'($urandom_range(0, 5));
            if (kind >= 1 && kind <= 3) kind = 1;
            else if (kind >= 4)         kind = kind - 2;
            for (int k = 0; k < kind; k++) bus.rd_hit[$urandom_range(0, NUM_RDATA-1)] = 1'b1;
            bus.valid_rd = ($urandom_range(0, 3) != 0);
            bus.err_clr  = ($urandom_range(0, 15) == 0);
            hresetn      = ($urandom_range(0, 63) != 0);
            tick();
        end
        hresetn = 1'b1;
        go_idle();
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
